// File: rtl/dsp48a1_pkg.sv
// ---------------------------------------------------------------------------
// dsp48a1_pkg
//   Shared definitions for the DSP48A1 slice datapath.
//   - Operand/product/accumulator widths.
//   - X mux select codes (OPMODE[1:0]) and Z mux select codes (OPMODE[3:2]).
// ---------------------------------------------------------------------------
package dsp48a1_pkg;

    localparam int A_W = 18;   // A/B/D operand width
    localparam int M_W = 36;   // product width
    localparam int P_W = 48;   // post-adder / accumulator width

    // X multiplexer selects, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    // Z multiplexer selects, OPMODE[3:2]
    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

endpackage

// File: rtl/pipe_reg_async.sv
// ---------------------------------------------------------------------------
// pipe_reg_async
//   Optional pipeline register. With pipeline != 0 it is a register with
//   clock enable and asynchronous active-high clear; with pipeline == 0 it is
//   a plain wire and clk/rst/ce are ignored.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high clear
//   ce   in   capture enable
//   d    in   [size-1:0] data in
//   q    out  [size-1:0] registered (or bypassed) data out
// ---------------------------------------------------------------------------
module pipe_reg_async #(
    parameter int size     = 1,
    parameter int pipeline = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [size-1:0] d,
    output logic [size-1:0] q
);

    generate
        if (pipeline != 0) begin : g_reg
            logic [size-1:0] q_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= '0;
                end else if (ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_wire
            // Control inputs have no function in bypass mode.
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/mult_post_adder.sv
// ---------------------------------------------------------------------------
// mult_post_adder
//   Multiplier and post-adder/accumulator stage of the DSP48A1 slice.
//   A1*B1 (unsigned 18x18) goes through MREG; the X and Z muxes feed a
//   48-bit adder/subtractor (computed 49 bits wide) whose result lands in
//   PREG, with the top bit captured as carry/borrow in CYO.
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   CEM, CEC, CEP          clock enables for M, C and P/CYO
//   CECARRYIN              clock enable for the carry-in register CYI
//   OPMODE [7:0]           [1:0] X sel, [3:2] Z sel, [5] carry-in, [7] subtract
//   A1, B1, D1 [17:0]      operands; D1[11:0] used in the X=3 concatenation
//   C, PCIN [47:0]         C operand and P cascade input
//   CARRYIN                cascade carry-in
//   M [35:0]               product after MREG
//   P, PCOUT [47:0]        post-adder result after PREG (PCOUT == P)
//   CARRYOUT, CARRYOUTF    carry/borrow out after CYO (identical)
// ---------------------------------------------------------------------------
module mult_post_adder
    import dsp48a1_pkg::*;
#(
    parameter int    MREG        = 1,
    parameter int    CREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CEM,
    input  logic           CEC,
    input  logic           CEP,
    input  logic           CECARRYIN,
    input  logic [7:0]     OPMODE,
    input  logic [A_W-1:0] A1,
    input  logic [A_W-1:0] B1,
    input  logic [A_W-1:0] D1,
    input  logic [P_W-1:0] C,
    input  logic [P_W-1:0] PCIN,
    input  logic           CARRYIN,
    output logic [M_W-1:0] M,
    output logic [P_W-1:0] P,
    output logic [P_W-1:0] PCOUT,
    output logic           CARRYOUT,
    output logic           CARRYOUTF
);

    logic [M_W-1:0] product;
    logic [M_W-1:0] m_q;
    logic [P_W-1:0] c_q;
    logic           cin_src;
    logic           cin_q;
    logic [P_W-1:0] x_mux;
    logic [P_W-1:0] z_mux;
    logic [P_W:0]   sum;
    logic [P_W-1:0] p_q;
    logic           co_q;

    // D1[17:12], OPMODE[6] and OPMODE[4] have no function in this stage.
    logic unused_ok;
    assign unused_ok = &{1'b0, D1[17:12], OPMODE[6], OPMODE[4]};

    // Zero-extend both operands so the multiply is evaluated at full width.
    assign product = {{(M_W-A_W){1'b0}}, A1} * {{(M_W-A_W){1'b0}}, B1};

    pipe_reg_async #(.size(M_W), .pipeline(MREG)) u_mreg (
        .clk(CLK), .rst(RST), .ce(CEM), .d(product), .q(m_q)
    );

    pipe_reg_async #(.size(P_W), .pipeline(CREG)) u_creg (
        .clk(CLK), .rst(RST), .ce(CEC), .d(C), .q(c_q)
    );

    assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : OPMODE[5];

    pipe_reg_async #(.size(1), .pipeline(CARRYINREG)) u_cyi (
        .clk(CLK), .rst(RST), .ce(CECARRYIN), .d(cin_src), .q(cin_q)
    );

    // X=2 / Z=2 feed the registered P back for accumulation.
    always_comb begin
        x_mux = '0;
        case (OPMODE[1:0])
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_q};
            X_P:     x_mux = p_q;
            default: x_mux = {D1[11:0], A1, B1};
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (OPMODE[3:2])
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = PCIN;
            Z_P:     z_mux = p_q;
            default: z_mux = c_q;
        endcase
    end

    // Subtraction is Z - (X + CIN) at 49 bits, so bit 48 is the borrow.
    always_comb begin
        sum = '0;
        if (OPMODE[7]) begin
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_q});
        end else begin
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_q};
        end
    end

    pipe_reg_async #(.size(P_W), .pipeline(PREG)) u_preg (
        .clk(CLK), .rst(RST), .ce(CEP), .d(sum[P_W-1:0]), .q(p_q)
    );

    pipe_reg_async #(.size(1), .pipeline(CARRYOUTREG)) u_cyo (
        .clk(CLK), .rst(RST), .ce(CEP), .d(sum[P_W]), .q(co_q)
    );

    assign M         = m_q;
    assign P         = p_q;
    assign PCOUT     = p_q;
    assign CARRYOUT  = co_q;
    assign CARRYOUTF = co_q;

endmodule

// File: tb/tb_mult_post_adder.sv
// ---------------------------------------------------------------------------
// tb_mult_post_adder
//   Self-checking bench for mult_post_adder with default parameters.
//   Directed vector table, hand-written reset / clock-enable sequences and a
//   randomized phase compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_post_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cem, cec, cep, cecarryin;
    logic [7:0]  opmode;
    logic [17:0] a1, b1, d1;
    logic [47:0] c, pcin;
    logic        carryin;
    logic [35:0] m;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    int errors = 0;
    int checks = 0;

    // {carryout, m, p}
    logic [84:0] exp_q[$];

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [7:0]  op;
        logic [35:0] exp_m;
        logic [47:0] exp_p;
        logic        exp_co;
    } vec_t;

    vec_t vecs[12];

    mult_post_adder dut (
        .CLK(clk), .RST(rst),
        .CEM(cem), .CEC(cec), .CEP(cep), .CECARRYIN(cecarryin),
        .OPMODE(opmode), .A1(a1), .B1(b1), .D1(d1),
        .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .M(m), .P(p), .PCOUT(pcout),
        .CARRYOUT(carryout), .CARRYOUTF(carryoutf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Plain integer arithmetic: the result is reduced mod 2^48 for P and
    // bit 48 of the 64-bit result is the carry (add) or borrow (subtract).
    logic [35:0] mdl_m;
    logic [47:0] mdl_c, mdl_p;
    logic        mdl_cyi, mdl_co;

    function automatic logic [48:0] model_result(
        input logic [7:0] op, input logic [35:0] mv, input logic [47:0] pv,
        input logic [47:0] cv, input logic cin, input logic [17:0] av,
        input logic [17:0] bv, input logic [17:0] dv, input logic [47:0] pc);
        longint unsigned xx, zz, rr;
        case (op[1:0])
            2'd0: xx = 0;
            2'd1: xx = longint'(mv);
            2'd2: xx = longint'(pv);
            default: xx = longint'(dv[11:0]) * 64'd68719476736 +
                          longint'(av) * 64'd262144 + longint'(bv);
        endcase
        case (op[3:2])
            2'd0: zz = 0;
            2'd1: zz = longint'(pc);
            2'd2: zz = longint'(pv);
            default: zz = longint'(cv);
        endcase
        if (op[7]) rr = zz - xx - longint'(cin);
        else       rr = zz + xx + longint'(cin);
        return rr[48:0];
    endfunction

    function automatic logic [35:0] model_prod(input logic [17:0] av, input logic [17:0] bv);
        longint unsigned pr;
        pr = longint'(av) * longint'(bv);
        return pr[35:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_m   <= '0;
            mdl_c   <= '0;
            mdl_p   <= '0;
            mdl_cyi <= 1'b0;
            mdl_co  <= 1'b0;
        end else begin
            if (cem)       mdl_m   <= model_prod(a1, b1);
            if (cec)       mdl_c   <= c;
            if (cecarryin) mdl_cyi <= opmode[5];
            if (cep) {mdl_co, mdl_p} <= model_result(opmode, mdl_m, mdl_p, mdl_c,
                                                     mdl_cyi, a1, b1, d1, pcin);
        end
    end

    // ---------------- checking ----------------
    task automatic check_field(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [35:0] em,
                             input logic [47:0] ep, input logic eco);
        check_field({tag, " M"}, {12'b0, m}, {12'b0, em});
        check_field({tag, " P"}, p, ep);
        check_field({tag, " PCOUT"}, pcout, ep);
        check_field({tag, " CARRYOUT"}, {47'b0, carryout}, {47'b0, eco});
        check_field({tag, " CARRYOUTF"}, {47'b0, carryoutf}, {47'b0, eco});
    endtask

    task automatic check_sb(input string tag);
        logic [84:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_out(tag, e[83:48], e[47:0], e[84]);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                         input logic [47:0] cv, input logic [7:0] op);
        a1 = a; b1 = b; d1 = d; c = cv; opmode = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [35:0] prev_m;
        logic [17:0] ra, rb;

        rst = 1'b1;
        cem = 1'b1; cec = 1'b1; cep = 1'b1; cecarryin = 1'b1;
        pcin = '0; carryin = 1'b0;
        drive(18'd0, 18'd0, 18'd0, 48'd0, 8'h00);

        //           a       b       d      c                     op     M       P                     CO
        vecs[0]  = '{18'd3,  18'd5,  18'd0, 48'd0,                8'h01, 36'd15, 48'd0,                1'b0};
        vecs[1]  = '{18'd3,  18'd5,  18'd0, 48'd0,                8'h01, 36'd15, 48'd15,               1'b0};
        vecs[2]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h00, 36'd20, 48'd0,                1'b0};
        vecs[3]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h09, 36'd20, 48'd20,               1'b0};
        vecs[4]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h09, 36'd20, 48'd40,               1'b0};
        vecs[5]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h09, 36'd20, 48'd60,               1'b0};
        vecs[6]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h09, 36'd20, 48'd80,               1'b0};
        vecs[7]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'h8C, 36'd20, 48'd0,                1'b0};
        vecs[8]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'hAC, 36'd20, 48'd0,                1'b0};
        vecs[9]  = '{18'd2,  18'd10, 18'd0, 48'd0,                8'hAC, 36'd20, 48'hFFFF_FFFF_FFFF,   1'b1};
        vecs[10] = '{18'd0,  18'd1,  18'd0, 48'hFFFF_FFFF_FFFF,   8'h0F, 36'd0,  48'd2,                1'b0};
        vecs[11] = '{18'd0,  18'd1,  18'd0, 48'hFFFF_FFFF_FFFF,   8'h0F, 36'd0,  48'd0,                1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 36'd0, 48'd0, 1'b0);
        rst = 1'b0;

        // Directed table: multiply, accumulate, subtract with borrow, wrap
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].op);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_m, vecs[i].exp_p, vecs[i].exp_co);
        end

        // Async reset mid-accumulation
        drive(18'd2, 18'd10, 18'd0, 48'd0, 8'h00);
        tick();
        drive(18'd2, 18'd10, 18'd0, 48'd0, 8'h09);
        repeat (4) tick();
        check_out("acc_pre_rst", 36'd20, 48'd80, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_out("rst_async", 36'd0, 48'd0, 1'b0);
        tick();
        check_out("rst_hold", 36'd0, 48'd0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("restart0", 36'd20, 48'd0, 1'b0);
        tick();
        check_out("restart1", 36'd20, 48'd20, 1'b0);
        tick();
        check_out("restart2", 36'd20, 48'd40, 1'b0);

        // CEP low: P holds while operands and M change
        cep = 1'b0;
        prev_m = 36'd20;
        for (int i = 0; i < 3; i++) begin
            ra = 18'($urandom);
            rb = 18'($urandom);
            drive(ra, rb, 18'd0, 48'd0, 8'h01);
            tick();
            prev_m = model_prod(ra, rb);
            check_out($sformatf("cep_hold%0d", i), prev_m, 48'd40, 1'b0);
        end
        cep = 1'b1;

        // CEM low: M holds, P follows the held M
        drive(18'd7, 18'd9, 18'd0, 48'd0, 8'h01);
        tick();
        check_out("cem_load", 36'd63, {12'b0, prev_m}, 1'b0);
        cem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(18'($urandom), 18'($urandom), 18'd0, 48'd0, 8'h01);
            tick();
            check_out($sformatf("cem_hold%0d", i), 36'd63, 48'd63, 1'b0);
        end
        cem = 1'b1;

        // Randomized phase against the reference model
        for (int i = 0; i < 400; i++) begin
            cem       = ($urandom_range(0, 3) != 0);
            cec       = ($urandom_range(0, 3) != 0);
            cep       = ($urandom_range(0, 3) != 0);
            cecarryin = ($urandom_range(0, 3) != 0);
            pcin      = {16'($urandom), 32'($urandom)};
            carryin   = 1'($urandom);
            drive(18'($urandom), 18'($urandom), 18'($urandom),
                  {16'($urandom), 32'($urandom)}, 8'($urandom));
            tick();
            exp_q.push_back({mdl_co, mdl_m, mdl_p});
            check_sb($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_post_adder.md
# mult_post_adder

Multiplier and post-adder/accumulator stage of the DSP48A1 slice. Consumes the pre-adder B path output (B1) together with the A path output (A1). It forms the 36-bit product in the M pipeline register, then selects X/Z operands into the 48-bit post-adder, whose result lands in the P register. It also produces the cascade (PCOUT) and carry outputs.

## Interface
- MREG, default 1: 1 = registered product, 0 = combinational bypass
- CREG, default 1: registered C input
- PREG, default 1: registered P output
- CARRYINREG, default 1: registered carry-in (CYI)
- CARRYOUTREG, default 1: registered carry-out (CYO)
- CARRYINSEL, default "OPMODE5": carry-in source, "OPMODE5" or "CARRYIN"
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-high; clears every register in the block
- CEM, CEC, CEP, CECARRYIN  in  1 each  clock enables for M, C, P/CYO and CYI
- OPMODE  in  8  bits [1:0] X select, [3:2] Z select, [5] carry-in, [7] add/sub
- A1  in  18  A-path operand
- B1  in  18  pre-adder B-path operand
- D1  in  18  D-path value; bits [11:0] used for the concatenation
- C  in  48  C operand
- PCIN  in  48  P cascade input
- CARRYIN  in  1  cascade carry input
- M  out  36  product (after MREG)
- P  out  48  post-adder result (after PREG)
- PCOUT  out  48  equals P
- CARRYOUT, CARRYOUTF  out  1  carry/borrow out; CARRYOUTF equals CARRYOUT

## Operation
- Product: unsigned 18x18 multiply, A1*B1 → 36 bits, passed through MREG.
- X mux, OPMODE[1:0]:
  - 0: zero
  - 1: {12'b0, M}
  - 2: P
  - 3: {D1[11:0], A1, B1}
- Z mux, OPMODE[3:2]:
  - 0: zero
  - 1: PCIN
  - 2: P
  - 3: C (after CREG)
- Carry-in source: OPMODE[5] or the CARRYIN port, per CARRYINSEL; passed through CYI.
- Post-adder, computed 49 bits wide:
  - OPMODE[7]=0: Z + X + CIN.
  - OPMODE[7]=1: Z − (X + CIN).
  - Bits [47:0] go to P; bit 48 goes to CYO/CARRYOUT.
  - All arithmetic wraps modulo 2^48. There is no saturation.
- Accumulate: X=2 or Z=2 feeds P back. These selects are legal only with PREG=1. With PREG=0 they are unsupported and are not verified.
- Each register with CE low holds its value. Each register whose parameter is 0 is replaced by a wire, and its CE is ignored.
- Reset:
  - RST asserts asynchronously and forces M, C, CYI, P and CARRYOUT to 0 immediately, independent of CE.
  - Outputs stay 0 while RST is high. Capture resumes on the first CLK edge after RST falls.
  - Reset mid-accumulation discards the running sum.
- RST and a CE asserted together: reset wins.

## Timing
- All registers enabled: A1/B1 sampled at edge n → M valid after edge n → P valid after edge n+1. Latency is 2 cycles.
- C path with CREG=1, PREG=1: 2 cycles. PCIN and D1/A1/B1 via X=3: 1 cycle, captured directly by PREG.
- OPMODE is not registered in this block. It must be stable in the cycle ending at the P-capture edge.
- CYI delays the carry by 1 cycle. To align, the carry must be presented together with the operands that enter MREG/CREG.
- Each parameter set to 0 reduces the latency of its path by 1 cycle.
- Accumulation with X=1, Z=2: P(k+1) = P(k) + M(k) on each CEP edge.

## Structure
- Shared package dsp48a1_pkg holds:
  - X select constants: X_ZERO, X_M, X_P, X_DAB
  - Z select constants: Z_ZERO, Z_PCIN, Z_P, Z_C
  - Width constants: 18/36/48
- One sub-module, pipe_reg_async:
  - Parameters size and pipeline.
  - Register-with-bypass mux with async active-high reset and enable.
  - Instanced for M, C, CYI, P and CYO.

## Test plan
- Multiply path: A1=3, B1=5, OPMODE=8'h01, all CE=1 → M=15 one cycle later, P=15 two cycles later, CARRYOUT=0.
- Accumulate: OPMODE=8'h09 (X=M, Z=P), A1=2, B1=10, held 4 cycles after P cleared → P = 20, 40, 60, 80 on successive edges.
- Subtract with borrow: OPMODE=8'h8C (Z=C, X=0, sub), C=0, CARRYINSEL=OPMODE5, OPMODE[5]=0 → P=0, CARRYOUT=0. Then OPMODE=8'hAC → P=48'hFFFF_FFFF_FFFF, CARRYOUT=1.
- Wrap-around: Z=C=48'hFFFF_FFFF_FFFF, X=DAB={12'h000,18'h0,18'h1}, add → P=0, CARRYOUT=1.
- Async reset mid-accumulation: assert RST between clock edges while P=80 → P, M, CARRYOUT read 0 before the next CLK edge. After release, accumulation restarts from 0.
- Clock enables: CEP=0 for 3 cycles while operands change → P holds its prior value. With CEM=0, M holds while P follows the held M.
